// File: rtl/histogram_bank_sequencer.sv
// Captures NUM_BANKS x NUM_BINS histogram bins into a shadow buffer on a strobe and
// streams them out one bank per beat on a registered valid/ready interface.
module histogram_bank_sequencer #(
    parameter int DATA_W    = 16,
    parameter int NUM_BINS  = 36,
    parameter int NUM_BANKS = 2,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                                 iclk,
    input  logic                                 ireset,
    input  logic                                 idata_en,
    input  logic                                 imode,
    input  logic [BANK_W-1:0]                    ibank_sel,
    input  logic [NUM_BANKS*NUM_BINS*DATA_W-1:0] ihist,
    input  logic                                 iready,
    output logic [NUM_BINS*DATA_W-1:0]           ohist,
    output logic                                 ovalid,
    output logic [BANK_W-1:0]                    obank,
    output logic                                 olast,
    output logic                                 obusy,
    output logic                                 odrop,
    output logic                                 oerr
);

    localparam int BANK_BITS  = NUM_BINS * DATA_W;
    localparam int TOTAL_BITS = NUM_BANKS * BANK_BITS;
    localparam logic [BANK_W:0]   BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);
    localparam logic [BANK_W-1:0] LAST_BANK  = BANK_W'(NUM_BANKS - 1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t                  state, state_next;
    logic [TOTAL_BITS-1:0]   shadow;
    logic [BANK_W-1:0]       end_bank;
    logic [BANK_W-1:0]       start_bank, stop_bank, next_bank;
    logic                    legal, load, advance, drop_next, err_next;

    function automatic logic [BANK_BITS-1:0] bank_slice(input logic [TOTAL_BITS-1:0] flat,
                                                        input logic [BANK_W-1:0]     b);
        return flat[int'(b)*BANK_BITS +: BANK_BITS];
    endfunction

    assign legal      = imode || ({1'b0, ibank_sel} < BANK_LIMIT);
    assign start_bank = imode ? '0 : ibank_sel;
    assign stop_bank  = imode ? LAST_BANK : ibank_sel;
    assign next_bank  = obank + BANK_W'(1);
    assign ovalid     = (state == S_SEND);
    assign obusy      = (state == S_SEND);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        drop_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            S_IDLE: begin
                if (idata_en) begin
                    if (legal) begin
                        load       = 1'b1;
                        state_next = S_SEND;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_SEND: begin
                // The final handshake frees the buffer, so a strobe here starts the next capture.
                if (iready && olast) begin
                    if (idata_en && legal) begin
                        load = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                        err_next   = idata_en;
                    end
                end else begin
                    advance   = iready;
                    drop_next = idata_en;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: all state below updates with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state    <= S_IDLE;
            ohist    <= '0;
            obank    <= '0;
            olast    <= 1'b0;
            end_bank <= '0;
            odrop    <= 1'b0;
            oerr     <= 1'b0;
        end else begin
            state <= state_next;
            odrop <= drop_next;
            oerr  <= err_next;
            if (load) begin
                end_bank <= stop_bank;
                obank    <= start_bank;
                olast    <= (start_bank == stop_bank);
                ohist    <= bank_slice(ihist, start_bank);
            end else if (advance) begin
                obank <= next_bank;
                olast <= (next_bank == end_bank);
                ohist <= bank_slice(shadow, next_bank);
            end
        end
    end

    // NOTE: the shadow buffer has no reset; it is always written before it is read.
    always_ff @(posedge iclk) begin
        if (load) begin
            shadow <= ihist;
        end
    end

endmodule

// File: doc/histogram_bank_sequencer.md
Name: histogram_bank_sequencer

Overview:
- Parametrised successor to the fixed two-bank orientation-histogram multiplexer in the dominant-orientation path.
- Captures NUM_BANKS x NUM_BINS histogram bins into a shadow buffer on a strobe, freeing the upstream accumulators immediately.
- Presents the captured banks one at a time on a registered valid/ready stream, either one selected bank (direct mode) or all banks in order (sequence mode).
- Feeds the peak/dominant-orientation search stage.

Parameters:
DATA_W, 16, bits per histogram bin
NUM_BINS, 36, bins per bank
NUM_BANKS, 2, banks per capture (>=1); BANK_W = max(1, clog2(NUM_BANKS)) is a derived localparam, not overridable

Ports:
iclk  in  1  clock
ireset  in  1  synchronous active-high reset
idata_en  in  1  capture strobe; ihist, imode and ibank_sel are sampled when it is high
imode  in  1  0 = direct (emit bank ibank_sel only), 1 = sequence (emit banks 0..NUM_BANKS-1)
ibank_sel  in  BANK_W  bank to emit in direct mode
ihist  in  NUM_BANKS*NUM_BINS*DATA_W  flat bins; bank b, bin k = ihist[(b*NUM_BINS+k)*DATA_W +: DATA_W]
iready  in  1  downstream accepts the current beat
ohist  out  NUM_BINS*DATA_W  current bank; bin k = ohist[k*DATA_W +: DATA_W]
ovalid  out  1  ohist/obank/olast are valid
obank  out  BANK_W  index of the bank on ohist
olast  out  1  final beat of the current capture
obusy  out  1  a capture is in progress; new strobes are dropped
odrop  out  1  one-cycle pulse: strobe rejected while busy
oerr  out  1  one-cycle pulse: direct-mode ibank_sel >= NUM_BANKS, strobe rejected

Behaviour:
- Reset (ireset high at a clock edge):
  - State goes to IDLE.
  - ohist=0, ovalid=0, obank=0, olast=0, obusy=0, odrop=0, oerr=0.
  - The shadow buffer is not reset; its contents are unobservable until the next capture.
  - Reset mid-stream aborts the capture; no further beats are issued.
- States: IDLE, SEND.
- IDLE, idata_en high with a legal request:
  - The whole ihist is copied into the shadow buffer.
  - Start bank cur = (imode ? 0 : ibank_sel) and end bank = (imode ? NUM_BANKS-1 : ibank_sel) are latched.
  - Next cycle: state=SEND, ovalid=1, obusy=1, ohist = bank cur, obank=cur, olast=(cur==end).
  - Latency from strobe to first valid beat is 1 cycle.
- Illegal request (IDLE, idata_en high, imode=0, ibank_sel >= NUM_BANKS): no capture, stay in IDLE, oerr=1 for one cycle.
- SEND, ovalid=1 and iready=0: ohist, obank, olast and ovalid hold stable.
- SEND, ovalid=1, iready=1, olast=0: cur increments; the next cycle shows bank cur+1. This sustains one beat per cycle.
- SEND, ovalid=1, iready=1, olast=1:
  - With idata_en=0: return to IDLE; next cycle ovalid=0, obusy=0, and ohist holds its last value.
  - With idata_en=1 in the same cycle: the new strobe is accepted as if in IDLE (back-to-back), and the next cycle shows the first beat of the new capture. No bubble, no odrop.
- idata_en in SEND at any other cycle: ignored, shadow unchanged, odrop=1 for one cycle.
- obusy = (state == SEND).
- odrop and oerr are registered, one cycle after the offending strobe.
- No arithmetic on bin data; bins pass bit-exact.
- NUM_BANKS=1: BANK_W=1, the only legal direct select is 0, and both modes emit a single beat with olast=1.
- Defaults (NUM_BANKS=2, NUM_BINS=36, DATA_W=16): bank 0 = input bins 0..35, bank 1 = input bins 36..71.

Test Plan:
- Direct mode: defaults, bin i = i+1, idata_en=1, imode=0, ibank_sel=1, iready=1 -> next cycle ovalid=1, obank=1, olast=1, ohist bin0=37, bin35=72; following cycle ovalid=0, obusy=0.
- Sequence mode with backpressure: imode=1, iready held low 3 cycles -> bank 0 (bin0=1) held stable for 3 cycles. Then iready=1 -> bank 1 (bin0=37, olast=1) next cycle, then ovalid=0.
- Shadow isolation and drop: after capture, change ihist to all 0xFFFF and pulse idata_en mid-stream -> odrop=1 for one cycle; emitted data is still the original values.
- Back-to-back: idata_en=1 on the accepted last beat with new data (bin i = 100+i, imode=0, sel=0) -> next cycle ovalid=1, obank=0, bin0=100; no idle cycle, odrop=0.
- Illegal select: NUM_BANKS=3, imode=0, ibank_sel=3 -> oerr=1 for one cycle, ovalid stays 0, obusy stays 0.
- Reset mid-stream: NUM_BANKS=4, sequence mode, assert ireset during bank 2 -> next cycle all outputs 0; the next strobe restarts cleanly at bank 0.
